// File: rtl/mdio_master_if.sv
// rtl/mdio_master_if.sv - command/status and MDIO pin bundle for mdio_master
interface mdio_master_if;
    logic [4:0]  phy_add;
    logic [4:0]  reg_add;
    logic [15:0] wr_data;
    logic        wren;
    logic        rden;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    modport master (
        input  phy_add, reg_add, wr_data, wren, rden, mdio_i,
        output busy, rd_data, rd_valid, rd_err, mdc, mdio_o, mdio_oe
    );

    modport slave (
        output phy_add, reg_add, wr_data, wren, rden, mdio_i,
        input  busy, rd_data, rd_valid, rd_err, mdc, mdio_o, mdio_oe
    );
endinterface

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO master, one register write/read per frame
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    mdio_master_if.master bus
);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;

    state_t        state;
    state_t        nxt_state;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic          is_wr;
    logic [31:0]   tx_sr;
    logic [15:0]   rx_sr;
    logic          ta_err;
    logic          tick;
    logic          mdc_rise;
    logic          mdc_fall;
    logic          last_bit;

    assign tick     = (div_cnt == DW'(CLK_DIV - 1));
    assign mdc_rise = tick && !bus.mdc;
    assign mdc_fall = tick && bus.mdc;

    always_comb begin
        nxt_state = state;
        last_bit  = 1'b0;
        case (state)
            S_PRE:  last_bit = (bit_cnt == 5'd31);
            S_HDR:  last_bit = (bit_cnt == 5'd13);
            S_TA:   last_bit = (bit_cnt == 5'd1);
            S_DATA: last_bit = (bit_cnt == 5'd15);
            S_END:  last_bit = 1'b1;
            default: last_bit = 1'b0;
        endcase
        if (last_bit) begin
            case (state)
                S_PRE:  nxt_state = S_HDR;
                S_HDR:  nxt_state = S_TA;
                S_TA:   nxt_state = S_DATA;
                S_DATA: nxt_state = S_END;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            is_wr        <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            ta_err       <= 1'b0;
            bus.mdc      <= 1'b0;
            bus.mdio_o   <= 1'b1;
            bus.mdio_oe  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.wren || bus.rden) begin
                    // Everything after the preamble is shifted out of tx_sr;
                    // read frames pad TA/DATA with ones since the pin is released.
                    state       <= S_PRE;
                    is_wr       <= bus.wren;
                    tx_sr       <= {2'b01, (bus.wren ? 2'b01 : 2'b10), bus.phy_add, bus.reg_add,
                                    (bus.wren ? 2'b10 : 2'b11), (bus.wren ? bus.wr_data : 16'hFFFF)};
                    bit_cnt     <= '0;
                    div_cnt     <= '0;
                    ta_err      <= 1'b0;
                    bus.mdc     <= 1'b0;
                    bus.mdio_o  <= 1'b1;
                    bus.mdio_oe <= 1'b1;
                    bus.busy    <= 1'b1;
                end
            end else begin
                if (tick) begin
                    div_cnt <= '0;
                    bus.mdc <= ~bus.mdc;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end

                if (mdc_rise && !is_wr) begin
                    if (state == S_TA && bit_cnt == 5'd1)
                        ta_err <= bus.mdio_i;
                    if (state == S_DATA)
                        rx_sr <= {rx_sr[14:0], bus.mdio_i};
                end

                // Pin changes only on MDC falling edges, centring data on the rising edge.
                if (mdc_fall) begin
                    state   <= nxt_state;
                    bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                    case (nxt_state)
                        S_PRE: begin
                            bus.mdio_o  <= 1'b1;
                            bus.mdio_oe <= 1'b1;
                        end
                        S_HDR, S_TA, S_DATA: begin
                            bus.mdio_o  <= tx_sr[31];
                            tx_sr       <= {tx_sr[30:0], 1'b1};
                            bus.mdio_oe <= is_wr || (nxt_state == S_HDR);
                        end
                        S_END: begin
                            bus.mdio_o  <= 1'b1;
                            bus.mdio_oe <= 1'b0;
                        end
                        default: begin
                            bus.mdio_o  <= 1'b1;
                            bus.mdio_oe <= 1'b0;
                            bus.busy    <= 1'b0;
                            if (!is_wr) begin
                                bus.rd_data  <= rx_sr;
                                bus.rd_valid <= 1'b1;
                                bus.rd_err   <= ta_err;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - scoreboard bench for mdio_master at CLK_DIV 10 and 2
module tb_mdio_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    mdio_master_if i0 ();
    mdio_master_if i1 ();

    mdio_master #(.CLK_DIV(10)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.master));
    mdio_master #(.CLK_DIV(2))  u1 (.clk(clk), .rst_n(rst_n), .bus(i1.master));

    logic [4:0]  phy_a [2];
    logic [4:0]  reg_a [2];
    logic [15:0] dat_a [2];
    logic        wren_a [2];
    logic        rden_a [2];
    logic        mdio_i_a [2];
    logic        busy_a [2];
    logic        mdc_a [2];
    logic        o_a [2];
    logic        oe_a [2];
    logic        rv_a [2];
    logic        re_a [2];
    logic [15:0] rd_a [2];

    assign i0.phy_add = phy_a[0];  assign i1.phy_add = phy_a[1];
    assign i0.reg_add = reg_a[0];  assign i1.reg_add = reg_a[1];
    assign i0.wr_data = dat_a[0];  assign i1.wr_data = dat_a[1];
    assign i0.wren    = wren_a[0]; assign i1.wren    = wren_a[1];
    assign i0.rden    = rden_a[0]; assign i1.rden    = rden_a[1];
    assign i0.mdio_i  = mdio_i_a[0]; assign i1.mdio_i = mdio_i_a[1];
    assign busy_a[0] = i0.busy;     assign busy_a[1] = i1.busy;
    assign mdc_a[0]  = i0.mdc;      assign mdc_a[1]  = i1.mdc;
    assign o_a[0]    = i0.mdio_o;   assign o_a[1]    = i1.mdio_o;
    assign oe_a[0]   = i0.mdio_oe;  assign oe_a[1]   = i1.mdio_oe;
    assign rv_a[0]   = i0.rd_valid; assign rv_a[1]   = i1.rd_valid;
    assign re_a[0]   = i0.rd_err;   assign re_a[1]   = i1.rd_err;
    assign rd_a[0]   = i0.rd_data;  assign rd_a[1]   = i1.rd_data;

    typedef struct {
        int          sel;
        logic [64:0] bits;
        logic [64:0] oe;
        bit          is_rd;
        logic [15:0] rd_data;
        bit          rd_err;
    } exp_t;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          fidx_a [2];
    bit          abort_a [2];
    bit          phy_present [2];
    logic [15:0] phy_val [2];
    logic [15:0] last_rd [2];

    function automatic int div_of(input int s);
        return (s == 0) ? 10 : 2;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference frame straight from the Clause-22 field layout; write wins over read.
    task automatic push_exp(input int s, input bit wr, input bit rd,
                            input logic [4:0] p, input logic [4:0] r, input logic [15:0] d);
        exp_t e;
        if (!wr && !rd) return;
        e.sel   = s;
        e.is_rd = !wr;
        if (wr) begin
            e.bits   = {32'hFFFF_FFFF, 2'b01, 2'b01, p, r, 2'b10, d, 1'b1};
            e.oe     = {{64{1'b1}}, 1'b0};
            e.rd_err = 1'b0;
        end else begin
            e.bits     = {32'hFFFF_FFFF, 2'b01, 2'b10, p, r, 2'b11, 16'hFFFF, 1'b1};
            e.oe       = {{46{1'b1}}, 19'b0};
            e.rd_err   = !phy_present[s];
            last_rd[s] = phy_present[s] ? phy_val[s] : 16'hFFFF;
        end
        e.rd_data = last_rd[s];
        exp_q.push_back(e);
    endtask

    task automatic issue(input int s, input bit wr, input bit rd, input logic [4:0] p,
                         input logic [4:0] r, input logic [15:0] d, input bit accept);
        phy_a[s]  = p;
        reg_a[s]  = r;
        dat_a[s]  = d;
        wren_a[s] = wr;
        rden_a[s] = rd;
        if (accept) push_exp(s, wr, rd, p, r, d);
        @(negedge clk);
        wren_a[s] = 1'b0;
        rden_a[s] = 1'b0;
        phy_a[s]  = 5'($urandom);
        reg_a[s]  = 5'($urandom);
        dat_a[s]  = 16'($urandom);
        if (accept) chk("busy_after_accept", busy_a[s], 1'b1);
    endtask

    task automatic wait_idle(input int s);
        int n = 0;
        while (busy_a[s] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_bit(input int s, input int b);
        int n = 0;
        @(negedge clk);
        while (fidx_a[s] < b && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("bit_timeout", 1, 0);
    endtask

    task automatic monitor(input int s);
        bit pb = 0, pm = 0, po = 1, poe = 0, act = 0, cur_rd = 0;
        logic b, m, o, oe, rv;
        int cyc = 0, k = 0, first = -1, viol = 0;
        logic [64:0] go, goe, mask;
        exp_t e;
        forever begin
            @(negedge clk);
            b = busy_a[s]; m = mdc_a[s]; o = o_a[s]; oe = oe_a[s]; rv = rv_a[s];
            if (!pb && b === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].sel != s) begin
                    chk("spurious_frame", 1, 0);
                    act = 0;
                end else begin
                    act = 1; cyc = 0; k = 0; first = -1; viol = 0;
                    go = '0; goe = '0; fidx_a[s] = 0; cur_rd = exp_q[0].is_rd;
                end
            end
            if (act && b === 1'b1) begin
                cyc++;
                if (!pm && m) begin
                    if (k < 65) begin
                        go[64-k]  = o;
                        goe[64-k] = oe;
                    end
                    if (k == 0) first = cyc;
                    k++;
                end
                if (pm && !m) fidx_a[s]++;
                if (pb && (o !== po || oe !== poe) && !(pm && !m)) viol++;
            end
            // PHY responder: TA low on the second turnaround bit, then data MSB first.
            if (act && b === 1'b1 && cur_rd && phy_present[s]) begin
                if (fidx_a[s] == 47) mdio_i_a[s] = 1'b0;
                else if (fidx_a[s] >= 48 && fidx_a[s] <= 63) mdio_i_a[s] = phy_val[s][63 - fidx_a[s]];
                else mdio_i_a[s] = 1'b1;
            end else begin
                mdio_i_a[s] = 1'b1;
            end
            if (rv === 1'b1 && !(pb && b === 1'b0)) chk("stray_rd_valid", 1, 0);
            if (pb && b === 1'b0 && act) begin
                e = exp_q.pop_front();
                act = 0;
                if (abort_a[s]) begin
                    chk("abort_rd_valid", rv, 1'b0);
                    abort_a[s] = 0;
                end else begin
                    mask = e.oe | 65'd1;
                    chk("frame_bits", go & mask, e.bits & mask);
                    chk("frame_oe", goe, e.oe);
                    chk("busy_len", cyc, 130 * div_of(s));
                    chk("first_mdc_rise", first, div_of(s) + 1);
                    chk("mdc_rises", k, 65);
                    chk("pin_change_off_fall", viol, 0);
                    chk("rd_valid", rv, e.is_rd);
                    chk("rd_data", rd_a[s], e.rd_data);
                    chk("rd_err", re_a[s], e.rd_err);
                end
            end
            pb = (b === 1'b1); pm = (m === 1'b1); po = o; poe = oe;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            phy_a[s] = '0; reg_a[s] = '0; dat_a[s] = '0;
            wren_a[s] = 0; rden_a[s] = 0; mdio_i_a[s] = 1;
            fidx_a[s] = 0; abort_a[s] = 0; phy_present[s] = 1;
            phy_val[s] = '0; last_rd[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", busy_a[s], 1'b0);
            chk("rst_mdc", mdc_a[s], 1'b0);
            chk("rst_mdio_o", o_a[s], 1'b1);
            chk("rst_mdio_oe", oe_a[s], 1'b0);
            chk("rst_rd_data", rd_a[s], 16'h0);
            chk("rst_rd_valid", rv_a[s], 1'b0);
            chk("rst_rd_err", re_a[s], 1'b0);
        end
        rst_n = 1'b1;
        fork
            monitor(0);
            monitor(1);
        join_none
        @(negedge clk);

        issue(0, 1, 0, 5'd1, 5'd0, 16'h1100, 1);
        wait_idle(0);
        phy_present[0] = 1; phy_val[0] = 16'hABCD;
        issue(0, 0, 1, 5'd1, 5'd2, 16'h0, 1);
        wait_idle(0);
        phy_present[0] = 0;
        issue(0, 0, 1, 5'($urandom), 5'($urandom), 16'($urandom), 1);
        wait_idle(0);
        issue(0, 1, 1, 5'($urandom), 5'($urandom), 16'($urandom), 1);
        wait_idle(0);

        issue(0, 1, 0, 5'($urandom), 5'($urandom), 16'($urandom), 1);
        repeat (300) @(negedge clk);
        issue(0, 1, 0, 5'($urandom), 5'($urandom), 16'($urandom), 0);
        wait_idle(0);
        repeat (30) @(negedge clk);

        phy_present[0] = 1; phy_val[0] = 16'($urandom);
        issue(0, 0, 1, 5'($urandom), 5'($urandom), 16'h0, 1);
        wait_bit(0, 40);
        abort_a[0] = 1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_a[0], 1'b0);
        chk("abort_mdc", mdc_a[0], 1'b0);
        chk("abort_mdio_oe", oe_a[0], 1'b0);
        chk("abort_mdio_o", o_a[0], 1'b1);
        chk("abort_rd_data", rd_a[0], 16'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n = 1'b1;
        issue(0, 1, 0, 5'($urandom), 5'($urandom), 16'($urandom), 1);
        wait_idle(0);

        for (int i = 0; i < 4; i++) begin
            op = $urandom_range(0, 2);
            phy_present[0] = ($urandom_range(0, 3) != 0);
            phy_val[0] = 16'($urandom);
            issue(0, op != 1, op != 0, 5'($urandom), 5'($urandom), 16'($urandom), 1);
            wait_idle(0);
        end

        for (int i = 0; i < 10; i++) begin
            op = $urandom_range(0, 2);
            phy_present[1] = ($urandom_range(0, 3) != 0);
            phy_val[1] = 16'($urandom);
            issue(1, op != 1, op != 0, 5'($urandom), 5'($urandom), 16'($urandom), 1);
            wait_idle(1);
        end

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management master: accepts single-register write/read commands from the PHY configuration sequencer and serialises them onto the MDC/MDIO pins of the external PHY. It sits directly downstream of the configuration stage, which drives `phy_add`/`reg_add`/`wr_data`/`wren`/`rden` and waits on `busy`. Read data and a no-response flag are returned for status polling.

## Interface
- `CLK_DIV`, 10, MDC half-period in `clk` cycles (minimum 2); MDC = clk/(2·CLK_DIV)
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `phy_add`  in  5  PHY address, captured on accept
- `reg_add`  in  5  register address, captured on accept
- `wr_data`  in  16  write data, captured on accept
- `wren`  in  1  write request (level sampled, not required to be held)
- `rden`  in  1  read request
- `busy`  out  1  frame in progress; requests ignored while high
- `rd_data`  out  16  last read result, held until next read completes
- `rd_valid`  out  1  one-cycle pulse: read finished
- `rd_err`  out  1  one-cycle pulse with `rd_valid`: PHY did not drive TA low
- `mdc`  out  1  management clock
- `mdio_o`  out  1  MDIO drive value
- `mdio_oe`  out  1  MDIO output enable (1 = master drives)
- `mdio_i`  in  1  MDIO pin input

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, `mdc`=0, `mdio_o`=1, `mdio_oe`=0, `busy`=0, `rd_data`=0, `rd_valid`=0, `rd_err`=0, counters 0. Reset mid-frame aborts immediately; no partial completion pulse.
- Accept: in IDLE with `wren` or `rden` high → latch addresses/data/opcode, go PRE. Both high → write wins. Requests while `busy`=1 are dropped, not queued.
- States and bit counts (one bit = 2·CLK_DIV clk cycles):
  - PRE: 32 bits of 1.
  - HDR: 14 bits MSB first: ST=01, OP=01 write / 10 read, PHYAD[4:0], REGAD[4:0].
  - TA: 2 bits. Write: drive 1,0. Read: `mdio_oe`=0; sample `mdio_i` on 2nd TA bit; 1 → set error flag.
  - DATA: 16 bits MSB first. Write: drive `wr_data`. Read: `mdio_oe`=0, shift in `mdio_i` at each MDC rising edge.
  - END: 1 bit, `mdio_oe`=0, `mdio_o`=1, MDC keeps toggling.
  - → IDLE.
- Frame = 65 bit periods total for both ops.
- Read completion: on IDLE entry, `rd_data` ← shifted word, `rd_valid`=1, `rd_err`=error flag, for exactly one cycle. Write completion produces no pulse.

## Timing
- Divider counter runs 0..CLK_DIV-1 only outside IDLE; `mdc` toggles at terminal count. In IDLE `mdc` held 0.
- Cycle T: request sampled. T+1: `busy`=1, `mdio_oe`=1, `mdio_o`=1 (first preamble bit), `mdc`=0.
- `mdc` rises at T+1+CLK_DIV, falls at T+1+2·CLK_DIV; `mdio_o`/`mdio_oe` change only in the cycle `mdc` goes 1→0 (bit boundary), giving CLK_DIV cycles setup and hold around the PHY's rising-edge sample.
- Read sampling: `mdio_i` registered in the cycle `mdc` goes 0→1.
- `busy` high for exactly 65·2·CLK_DIV cycles (1300 at default); drops T+1+1300. `rd_valid` pulses in that same cycle.
- Earliest next accept: the cycle `busy` is first low (back-to-back requests lose no cycles beyond that).

## Test plan
- Write, CLK_DIV=10: `wren` 1 cycle, phy=1, reg=0, data=16'h1100 → MDIO bits on falling edges = 32×1, 01, 01, 00001, 00000, 10, 0001000100000000; `busy` high exactly 1300 cycles; no `rd_valid`.
- Read, PHY model drives TA 0 and 16'hABCD: `rden`, phy=1, reg=2 → OP=10, `mdio_oe`=0 from TA through END, `rd_data`=16'hABCD, `rd_valid`=1 one cycle, `rd_err`=0.
- Read with no PHY (pull-up, `mdio_i`=1) → `rd_data`=16'hFFFF, `rd_valid`=1, `rd_err`=1.
- `wren` and `rden` same cycle → write frame (OP=01); `wren` pulsed mid-frame → ignored, frame and `busy` duration unchanged.
- `rst_n`=0 at bit 40 of a read → next cycle `busy`=0, `mdc`=0, `mdio_oe`=0, `mdio_o`=1, no `rd_valid`; a new write afterwards completes normally.
- CLK_DIV=2 back-to-back writes from a sequencer waiting on `!busy` → MDC period 4 cycles, second frame starts the cycle after `busy` falls, both frames bit-exact.
